// File: rtl/data_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_responder_pkg
// Description : Shared definitions for the data SRAM responder.
//               Holds the MMIO register offsets, the default MMIO window base,
//               the read-data source select type, and a byte-mask merge
//               helper used by both the RAM and the MMIO register file.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package data_sram_responder_pkg;

  // Default MMIO window. Only bits [31:16] take part in the decode.
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hbfaf_0000;

  // MMIO register offsets within the window (addr[15:0]).
  localparam logic [15:0] LED_OFF    = 16'hf000;
  localparam logic [15:0] NUM_OFF    = 16'hf010;
  localparam logic [15:0] TIMER_OFF  = 16'he000;
  localparam logic [15:0] SWITCH_OFF = 16'hf020;
  localparam logic [15:0] SIMU_OFF   = 16'hfff0;

  // Source of the registered read data.
  typedef enum logic {
    SEL_RAM  = 1'b0,
    SEL_MMIO = 1'b1
  } rdata_sel_t;

  // Replace each byte i of old_word with the same byte of new_word when
  // wen[i] is set.
  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  wen
  );
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_responder_if
// Description : CPU data SRAM bus (en / wen / addr / wdata / rdata).
// Ports       : none; signals grouped into modports
//               master - CPU side, drives the request, receives rdata
//               slave  - responder side, receives the request, drives rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface data_sram_responder_if;

  logic        en;     // request valid this cycle
  logic [3:0]  wen;    // byte write enables; 0 = read
  logic [31:0] addr;   // byte address; bits [1:0] ignored
  logic [31:0] wdata;  // write data
  logic [31:0] rdata;  // read data, valid the cycle after the request

  modport master (
    output en,
    output wen,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  en,
    input  wen,
    input  addr,
    input  wdata,
    output rdata
  );

endinterface
`default_nettype wire

// File: rtl/sram_byte_ram.sv
`default_nettype none
// ============================================================================
// Module      : sram_byte_ram
// Description : Synchronous, read-first, byte-writable RAM of 2^ADDR_W
//               32-bit words. The array has no reset.
// Ports       : clk   - clock
//               en    - access enable (read and/or write)
//               wen   - byte write enables
//               idx   - word index
//               wdata - write data
//               rdata - registered read data (pre-write word on a write)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_byte_ram
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // rdata samples the array before the write lands: read-first.
  // rdata only moves on an enabled access, so it holds while idle.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[idx];
      if (|wen) begin
        mem[idx] <= merge_bytes(mem[idx], wdata, wen);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_responder
// Description : Responder for the CPU data SRAM port. Decodes each request to
//               either the byte-writable RAM or the MMIO register file (LED,
//               numeric display, free-running timer, switches, sim flag) and
//               returns read data one cycle later.
// Ports       : clk       - clock
//               reset     - asynchronous, active-high reset
//               data_sram - data SRAM bus, slave side
//               switch_in - board switch levels
//               led       - LED register
//               num_data  - numeric-display register
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter logic [31:0] SIMU_FLAG = 32'hffff_ffff
) (
  input  logic                  clk,
  input  logic                  reset,
  data_sram_responder_if.slave  data_sram,
  input  logic [7:0]            switch_in,
  output logic [15:0]           led,
  output logic [31:0]           num_data
);

  logic              w_is_mmio;
  logic [15:0]       w_off;
  logic              w_mmio_wr;
  logic [31:0]       w_mmio_rdata;
  logic [31:0]       w_led_word;
  logic [31:0]       w_ram_rdata;
  logic [ADDR_W-1:0] w_ram_idx;
  logic              w_unused;

  logic [31:0]       r_timer;
  logic [31:0]       r_mmio_rdata;
  rdata_sel_t        r_sel;

  // ---------------------------------------------------------------- decode
  assign w_is_mmio = (data_sram.addr[31:16] == MMIO_BASE[31:16]);
  assign w_off     = data_sram.addr[15:0];
  assign w_mmio_wr = data_sram.en && w_is_mmio && (|data_sram.wen);
  // Upper address bits beyond the index simply alias.
  assign w_ram_idx = data_sram.addr[ADDR_W+1:2];

  // LED is 16 bits wide, so only the two low byte enables apply.
  assign w_led_word = merge_bytes({16'h0000, led}, data_sram.wdata,
                                  {2'b00, data_sram.wen[1:0]});

  // Byte-lane address bits and the unused upper LED merge half.
  assign w_unused = &{1'b0, data_sram.addr[1:0], w_led_word[31:16]};

  // ------------------------------------------------------------------ RAM
  sram_byte_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (data_sram.en && !w_is_mmio),
    .wen   (data_sram.wen),
    .idx   (w_ram_idx),
    .wdata (data_sram.wdata),
    .rdata (w_ram_rdata)
  );

  // ------------------------------------------------------ MMIO read mux
  // Reads the register values before this edge's updates, so a write plus
  // read of the same register returns the old value.
  always_comb begin
    w_mmio_rdata = 32'h0000_0000;
    case (w_off)
      LED_OFF:    w_mmio_rdata = {16'h0000, led};
      NUM_OFF:    w_mmio_rdata = num_data;
      TIMER_OFF:  w_mmio_rdata = r_timer;
      SWITCH_OFF: w_mmio_rdata = {24'h00_0000, switch_in};
      SIMU_OFF:   w_mmio_rdata = SIMU_FLAG;
      default:    w_mmio_rdata = 32'h0000_0000;
    endcase
  end

  // ------------------------------------------------ MMIO register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led          <= 16'h0000;
      num_data     <= 32'h0000_0000;
      r_timer      <= 32'h0000_0000;
      r_mmio_rdata <= 32'h0000_0000;
      // Selecting the cleared MMIO holding register makes rdata read 0
      // after reset regardless of what the RAM output register holds.
      r_sel        <= SEL_MMIO;
    end else begin
      if (w_mmio_wr && (w_off == LED_OFF)) begin
        led <= w_led_word[15:0];
      end
      if (w_mmio_wr && (w_off == NUM_OFF)) begin
        num_data <= merge_bytes(num_data, data_sram.wdata, data_sram.wen);
      end
      // A timer write replaces that edge's increment.
      if (w_mmio_wr && (w_off == TIMER_OFF)) begin
        r_timer <= merge_bytes(r_timer, data_sram.wdata, data_sram.wen);
      end else begin
        r_timer <= r_timer + 32'd1;
      end
      // Source select is captured with the request so rdata holds on idle.
      if (data_sram.en) begin
        r_sel        <= w_is_mmio ? SEL_MMIO : SEL_RAM;
        r_mmio_rdata <= w_mmio_rdata;
      end
    end
  end

  assign data_sram.rdata = (r_sel == SEL_RAM) ? w_ram_rdata : r_mmio_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sram_responder
// Description : Self-checking bench for data_sram_responder. A table of
//               single-cycle requests with hand-computed expectations, plus
//               hand-written sequences for reset, timer and wrap behaviour.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_responder;

  localparam logic [31:0] A_LED   = 32'hbfaf_f000;
  localparam logic [31:0] A_NUM   = 32'hbfaf_f010;
  localparam logic [31:0] A_TIMER = 32'hbfaf_e000;
  localparam logic [31:0] A_SW    = 32'hbfaf_f020;
  localparam logic [31:0] A_SIMU  = 32'hbfaf_fff0;
  localparam logic [31:0] A_HOLE  = 32'hbfaf_1234;

  // chk bits: [0] rdata, [1] led, [2] num_data
  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  sw;
    logic [2:0]  chk;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
    logic [31:0] exp_num;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  switch_in = 8'h00;
  logic [15:0] led;
  logic [31:0] num_data;

  int n_total = 0;
  int n_pass  = 0;
  vec_t tbl[$];

  data_sram_responder_if bus();

  data_sram_responder dut (
    .clk       (clk),
    .reset     (reset),
    .data_sram (bus),
    .switch_in (switch_in),
    .led       (led),
    .num_data  (num_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
  endtask

  // Present one request for one clock edge, then sample just after it.
  task automatic req(input logic en, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.en    = en;
    bus.wen   = wen;
    bus.addr  = addr;
    bus.wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [7:0] sw, input logic [2:0] chk,
                     input logic [31:0] er, input logic [15:0] el,
                     input logic [31:0] enm);
    vec_t v;
    v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata; v.sw = sw;
    v.chk = chk; v.exp_rdata = er; v.exp_led = el; v.exp_num = enm;
    tbl.push_back(v);
  endtask

  initial begin
    bus.en = 1'b0; bus.wen = 4'h0; bus.addr = '0; bus.wdata = '0;

    // ---------------- reset: held three cycles
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_num", num_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    req(1'b1, 4'h0, A_TIMER, 32'h0);
    n_total++;
    if (bus.rdata < 32'd4) n_pass++;
    else $display("FAIL timer_after_reset: actual=%08h required=<4", bus.rdata);

    // ---------------- table
    add(1, 4'hf, 32'h0000_0040, 32'h1234_5678, 8'h00, 3'b000, 0, 0, 0);
    add(1, 4'h2, 32'h0000_0040, 32'h0000_ab00, 8'h00, 3'b000, 0, 0, 0);
    add(1, 4'h0, 32'h0000_0040, 32'h0,         8'h00, 3'b001, 32'h1234_ab78, 0, 0);
    add(1, 4'hf, 32'h0000_0200, 32'hdead_beef, 8'h00, 3'b000, 0, 0, 0);
    add(1, 4'hf, 32'h0000_0200, 32'h0,         8'h00, 3'b001, 32'hdead_beef, 0, 0);
    add(1, 4'h0, 32'h0000_0200, 32'h0,         8'h00, 3'b001, 32'h0, 0, 0);
    add(1, 4'hf, 32'h0004_0000, 32'h0000_0055, 8'h00, 3'b000, 0, 0, 0);
    add(1, 4'h0, 32'h0000_0000, 32'h0,         8'h00, 3'b001, 32'h0000_0055, 0, 0);
    add(1, 4'hf, A_LED,         32'hffff_00a5, 8'h00, 3'b011, 32'h0, 16'h00a5, 0);
    add(1, 4'hf, A_NUM,         32'h0000_0007, 8'h00, 3'b101, 32'h0, 0, 32'h7);
    add(1, 4'h0, A_SW,          32'h0,         8'h3c, 3'b001, 32'h0000_003c, 0, 0);
    add(1, 4'h0, A_SIMU,        32'h0,         8'h00, 3'b001, 32'hffff_ffff, 0, 0);
    add(1, 4'h0, A_HOLE,        32'h0,         8'h00, 3'b001, 32'h0, 0, 0);
    add(1, 4'hf, A_HOLE,        32'hffff_ffff, 8'h00, 3'b011, 32'h0, 16'h00a5, 0);
    add(1, 4'hc, A_LED,         32'h1234_5678, 8'h00, 3'b011, 32'h0000_00a5, 16'h00a5, 0);
    add(1, 4'hf, 32'hbfae_f000, 32'h0000_00ff, 8'h00, 3'b010, 0, 16'h00a5, 0);
    add(1, 4'hc, A_NUM,         32'haabb_ccdd, 8'h00, 3'b101, 32'h7, 0, 32'haabb_0007);
    add(0, 4'h0, 32'h0,         32'h0,         8'h00, 3'b001, 32'h7, 0, 0);
    add(1, 4'h0, A_NUM,         32'h0,         8'h00, 3'b001, 32'haabb_0007, 0, 0);
    add(1, 4'h0, 32'hbfae_f000, 32'h0,         8'h00, 3'b001, 32'h0000_00ff, 0, 0);
    add(1, 4'h0, 32'h0000_0040, 32'h0,         8'h00, 3'b001, 32'h1234_ab78, 0, 0);
    add(0, 4'h0, A_SIMU,        32'h0,         8'h00, 3'b001, 32'h1234_ab78, 0, 0);

    foreach (tbl[i]) begin
      switch_in = tbl[i].sw;
      req(tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].chk[0]) check($sformatf("row%0d_rdata", i), bus.rdata, tbl[i].exp_rdata);
      if (tbl[i].chk[1]) check($sformatf("row%0d_led", i), {16'h0, led}, {16'h0, tbl[i].exp_led});
      if (tbl[i].chk[2]) check($sformatf("row%0d_num", i), num_data, tbl[i].exp_num);
    end
    switch_in = 8'h00;

    // ---------------- timer: write, idle, read, wrap, masked write
    req(1'b1, 4'hf, A_TIMER, 32'hffff_fffe);
    req(1'b0, 4'h0, A_TIMER, 32'h0);
    req(1'b1, 4'h0, A_TIMER, 32'h0);
    check("timer_pre_wrap", bus.rdata, 32'hffff_ffff);
    req(1'b1, 4'h0, A_TIMER, 32'h0);
    check("timer_wrap", bus.rdata, 32'h0000_0000);
    req(1'b1, 4'h0, A_TIMER, 32'h0);
    check("timer_incr", bus.rdata, 32'h0000_0001);
    // Timer is 2 at this edge; byte 1 replaced, no increment.
    req(1'b1, 4'h2, A_TIMER, 32'h0000_ab00);
    check("timer_wr_old", bus.rdata, 32'h0000_0002);
    req(1'b1, 4'h0, A_TIMER, 32'h0);
    check("timer_masked", bus.rdata, 32'h0000_ab02);
    req(1'b1, 4'h0, A_TIMER, 32'h0);
    check("timer_resume", bus.rdata, 32'h0000_ab03);

    // ---------------- reset mid-request aborts the pending read
    @(negedge clk);
    bus.en = 1'b1; bus.wen = 4'h0; bus.addr = 32'h0000_0040;
    reset = 1'b1;
    #1;
    check("async_reset_rdata", bus.rdata, 32'h0);
    check("async_reset_led", {16'h0, led}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_rdata", bus.rdata, 32'h0);
    check("post_reset_num", num_data, 32'h0);
    req(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    check("ram_kept", bus.rdata, 32'h1234_ab78);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
